data_block_memory: RTL and testbench

//  Multi-cycle, block-organised data memory directly downstream of the data cache.

---
 rtl/data_block_memory.sv | 62 ++++++
 tb/tb_data_block_memory.sv | 126 ++++++++++++
 2 files changed

// File: rtl/data_block_memory.sv
// data_block_memory: 64-block multi-cycle memory behind the data cache, busywait handshake.
// One request at a time: IDLE accepts, ACCESS counts down the latency, DONE drops busywait for a cycle.
module data_block_memory #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic wr_q, wr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic req, accept, fire;
  assign req    = mem_read | mem_write;
  assign accept = state_q == IDLE && req;
  assign fire   = state_q == ACCESS && count_q == 4'd0;
  always_comb begin
    state_d = accept ? ACCESS : fire ? DONE : state_q == DONE ? IDLE : state_q;
    count_d = accept ? 4'(LATENCY - 1) : count_q != 4'd0 ? count_q - 4'd1 : count_q;
    addr_d  = accept ? mem_address : addr_q;
    wdata_d = accept ? mem_writedata : wdata_q;
    wr_d    = accept ? mem_write : wr_q;
    rdata_d = fire && !wr_q ? mem_q[addr_q] : rdata_q;
    mem_d   = mem_q;
    if (fire && wr_q) mem_d[addr_q] = wdata_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end
  // Busy in the request's first IDLE cycle so the cache never sees an early completion.
  assign mem_busywait = !reset && (state_q == ACCESS || accept);
  assign mem_readdata = rdata_q;
endmodule

// File: tb/tb_data_block_memory.sv
// tb_data_block_memory: directed tests against a transaction-level model of the block memory.
module tb_data_block_memory;
  localparam int LAT = 5;
  logic clock, reset, mem_read, mem_write, mem_busywait;
  logic [5:0] mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  int errors = 0, checks = 0;
  bit chk = 0;
  logic [31:0] m_mem [64];
  logic [31:0] m_rd, m_d;
  logic [5:0] m_a;
  bit m_wr, m_done;
  int m_left;
  data_block_memory dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  // m_left = edges remaining until the pending operation takes effect.
  always @(posedge clock) begin
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_rd = 32'h0; m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_wr) m_mem[m_a] = m_d; else m_rd = m_mem[m_a];
        m_done = 1;
      end
    end else if (m_done) m_done = 0;
    else if (mem_read || mem_write) begin
      m_wr = mem_write; m_a = mem_address; m_d = mem_writedata; m_left = LAT;
    end
  end
  always @(negedge clock) if (chk) begin
    logic eb;
    eb = !reset && (m_left > 0 || (!m_done && (mem_read || mem_write)));
    checks += 2;
    if (mem_busywait !== eb) begin
      errors++; $display("FAIL busywait t=%0t got=%b want=%b", $time, mem_busywait, eb);
    end
    if (mem_readdata !== m_rd) begin
      errors++; $display("FAIL readdata t=%0t got=%h want=%h", $time, mem_readdata, m_rd);
    end
  end
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic run(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                     input bit chg, output int busy, output int total);
    busy = 0; total = 0;
    #1 mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (mem_busywait) begin busy++; total++; end
      else if (busy > 0) return;
      else total++;
      if (i == 1 && chg) begin #1 mem_address = 6'h04; mem_writedata = 32'h0BADF00D; end
      @(negedge clock);
    end
    errors++; checks++;
    $display("FAIL timeout addr=%h got=busy want=done", a);
  endtask
  task automatic drop;
    #1 mem_read = 0; mem_write = 0;
    @(negedge clock);
  endtask
  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    int b, t;
    run(1, 0, a, 32'h0, 0, b, t);
    chk32(name, mem_readdata, exp);
    drop();
  endtask
  initial begin
    int b, t, t2;
    mem_read = 0; mem_write = 1; mem_address = 6'h2A; mem_writedata = 32'h1; reset = 1;
    repeat (2) @(negedge clock);
    chk32("reset_busy", {31'h0, mem_busywait}, 32'h0);
    chk32("reset_rdata", mem_readdata, 32'h0);
    #1 mem_write = 0; reset = 0; chk = 1;
    @(negedge clock);
    rd_chk("t1_rd00", 6'h00, 32'h0);
    rd_chk("t1_rd3f", 6'h3F, 32'h0);
    run(0, 1, 6'h2A, 32'hDEADBEEF, 0, b, t);
    chk32("t2_busy", b, 6);
    drop();
    rd_chk("t2_rd2a", 6'h2A, 32'hDEADBEEF);
    run(1, 1, 6'h01, 32'h12345678, 0, b, t);
    chk32("t3_busy", b, 6);
    chk32("t3_keep", mem_readdata, 32'hDEADBEEF);
    drop();
    rd_chk("t3_rd01", 6'h01, 32'h12345678);
    run(0, 1, 6'h05, 32'hAABBCCDD, 0, b, t);
    run(1, 0, 6'h25, 32'h0, 0, b, t2);
    chk32("t4_total", t + t2, 13);
    chk32("t4_rd25", mem_readdata, 32'h0);
    drop();
    rd_chk("t4_rd05", 6'h05, 32'hAABBCCDD);
    #1 mem_write = 1; mem_address = 6'h10; mem_writedata = 32'hFFFFFFFF;
    repeat (3) @(negedge clock);
    #1 reset = 1; mem_write = 0;
    @(negedge clock);
    chk32("t5_busy", {31'h0, mem_busywait}, 32'h0);
    #1 reset = 0;
    @(negedge clock);
    rd_chk("t5_rd10", 6'h10, 32'h0);
    rd_chk("t5_rd01", 6'h01, 32'h0);
    run(0, 1, 6'h03, 32'h55AA55AA, 1, b, t);
    chk32("t6_busy", b, 6);
    drop();
    rd_chk("t6_rd03", 6'h03, 32'h55AA55AA);
    rd_chk("t6_rd04", 6'h04, 32'h0);
    run(0, 1, 6'h3F, 32'hCAFEF00D, 0, b, t);
    drop();
    rd_chk("top_rd3f", 6'h3F, 32'hCAFEF00D);
    chk32("model_pin", m_mem[63], 32'hCAFEF00D);
    chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
